// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier family.
//   booth_sel_t : radix-4 Booth partial-product selection (0, +M, +2M, -M, -2M)
//   state_t     : sequencer state of the iterative multiplier
//   MULT_WIDTH  : default operand width
package mult_pkg;

  localparam int unsigned MULT_WIDTH = 32;

  typedef enum logic [2:0] {
    SEL_ZERO,
    SEL_PM,
    SEL_P2M,
    SEL_NM,
    SEL_N2M
  } booth_sel_t;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

endpackage : mult_pkg

// File: rtl/booth_recoder.sv
// Radix-4 Booth recoder: maps the overlapping multiplier bit triple
// {q[i+1], q[i], q[i-1]} to the multiple of M to add this step.
// Purely combinational so an array multiplier can reuse it unchanged.
// Ports:
//   trip_i : 3-bit multiplier window, MSB first
//   sel_o  : selected multiple
module booth_recoder
  import mult_pkg::*;
(
  input  logic [2:0] trip_i,
  output booth_sel_t sel_o
);

  always_comb begin
    // NOTE: default assignment first so every path drives sel_o; otherwise a latch is inferred.
    sel_o = SEL_ZERO;
    unique case (trip_i)
      3'b000, 3'b111: sel_o = SEL_ZERO;
      3'b001, 3'b010: sel_o = SEL_PM;
      3'b011:         sel_o = SEL_P2M;
      3'b100:         sel_o = SEL_N2M;
      3'b101, 3'b110: sel_o = SEL_NM;
      default:        sel_o = SEL_ZERO;
    endcase
  end

endmodule : booth_recoder

// File: rtl/booth_mult_seq.sv
// Sequential signed multiplier, radix-4 Booth, two multiplier bits per cycle.
// An accepted operation takes WIDTH/2 iteration edges; result then feeds the
// HI/LO pair (upper half -> HI, lower half -> LO).
// Ports:
//   clk    : clock, rising edge
//   clear  : asynchronous active-high reset; abandons any operation in flight
//   start  : request, sampled only while ready=1
//   Q, M   : signed multiplier / multiplicand, captured on the accept edge
//   result : signed 2*WIDTH-bit product, holds the last completed value
//   ready  : idle and able to accept
//   done   : one-cycle pulse after completion
module booth_mult_seq
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 start,
  input  logic [WIDTH-1:0]     Q,
  input  logic [WIDTH-1:0]     M,
  output logic [2*WIDTH-1:0]   result,
  output logic                 ready,
  output logic                 done
);

  localparam int unsigned          CNT_W    = $clog2(WIDTH/2 + 1);
  localparam logic [CNT_W-1:0]     CNT_INIT = CNT_W'(WIDTH/2);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);

  state_t               state_q;
  // Accumulator and multiplicand carry two guard bits so that -2M for the
  // most negative M is representable.
  logic [WIDTH+1:0]     a_q;
  logic [WIDTH+1:0]     mr_q;
  logic [WIDTH-1:0]     qr_q;
  logic                 qm1_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 ready_q;
  logic                 done_q;

  booth_sel_t           sel;
  logic [WIDTH+1:0]     mult;
  logic [WIDTH+1:0]     a_sum;
  logic [WIDTH+1:0]     a_d;
  logic [WIDTH-1:0]     qr_d;
  logic                 qm1_d;

  booth_recoder u_recoder (
    .trip_i ({qr_q[1:0], qm1_q}),
    .sel_o  (sel)
  );

  // One iteration: add the selected multiple, then arithmetic-shift the
  // combined {A, Qr, q_m1} register right by two.
  always_comb begin
    mult = '0;
    unique case (sel)
      SEL_PM:  mult = mr_q;
      SEL_P2M: mult = {mr_q[WIDTH:0], 1'b0};
      SEL_NM:  mult = -mr_q;
      SEL_N2M: mult = -{mr_q[WIDTH:0], 1'b0};
      default: mult = '0;
    endcase
    a_sum = a_q + mult;
    a_d   = {{2{a_sum[WIDTH+1]}}, a_sum[WIDTH+1:2]};
    qr_d  = {a_sum[1:0], qr_q[WIDTH-1:2]};
    qm1_d = qr_q[1];
  end

  // NOTE: every register here is a small flop, not a memory, so all of them
  // are reset; clear must leave no trace of an abandoned operation.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q  <= IDLE;
      a_q      <= '0;
      mr_q     <= '0;
      qr_q     <= '0;
      qm1_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start && ready_q) begin
            a_q     <= '0;
            mr_q    <= {{2{M[WIDTH-1]}}, M};
            qr_q    <= Q;
            qm1_q   <= 1'b0;
            cnt_q   <= CNT_INIT;
            ready_q <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_d;
          qr_q  <= qr_d;
          qm1_q <= qm1_d;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            // The low WIDTH bits of A plus the shifted multiplier register
            // hold the full product after the last shift.
            result_q <= {a_d[WIDTH-1:0], qr_d};
            ready_q  <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign ready  = ready_q;
  assign done   = done_q;

endmodule : booth_mult_seq

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq (WIDTH=32): reset state, signed and corner
// products, latency and done-pulse width, start-while-busy, back-to-back
// accept, asynchronous clear mid-operation, plus signed random pairs.
module tb_booth_mult_seq;

  localparam int unsigned W = 32;

  logic            clk;
  logic            clear;
  logic            start;
  logic [W-1:0]    Q;
  logic [W-1:0]    M;
  logic [2*W-1:0]  result;
  logic            ready;
  logic            done;

  int n_checks = 0;
  int n_errors = 0;

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .clear  (clear),
    .start  (start),
    .Q      (Q),
    .M      (M),
    .result (result),
    .ready  (ready),
    .done   (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at the falling edge after the accept edge. Waits (bounded) for
  // done, then checks latency, busy behaviour, product and pulse width.
  task automatic wait_done(input string tag, input logic [63:0] exp, input logic keep_start);
    int           lat     = 0;
    logic         busy_ok = 1'b1;
    logic [63:0]  prev    = result;
    while (done !== 1'b1 && lat < 40) begin
      if (ready !== 1'b0 || result !== prev) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'd16);
    check({tag, " busy"}, 64'(busy_ok), 64'd1);
    check({tag, " ready"}, 64'(ready), 64'd1);
    check({tag, " result"}, result, exp);
    start = keep_start;
    @(negedge clk);
    check({tag, " done width"}, 64'(done), 64'd0);
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] q, input logic [W-1:0] m,
                       input logic [63:0] exp);
    @(negedge clk);
    Q = q;
    M = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Operands are registered: scrambling them must not matter.
    Q = $urandom;
    M = $urandom;
    wait_done(tag, exp, 1'b0);
  endtask

  initial begin
    clear = 1'b1;
    start = 1'b0;
    Q     = '0;
    M     = '0;
    #12;
    check("reset ready", 64'(ready), 64'd1);
    check("reset done", 64'(done), 64'd0);
    check("reset result", result, 64'd0);
    @(negedge clk);
    clear = 1'b0;

    do_op("100*3", 32'd100, 32'd3, 64'd300);
    do_op("-7*5", 32'hFFFF_FFF9, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFDD);
    do_op("min*min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    do_op("-1*-1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    do_op("max*min", 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
    do_op("zero*m", 32'd0, 32'd123, 64'd0);
    do_op("-1*max", 32'hFFFF_FFFF, 32'h7FFF_FFFF, 64'hFFFF_FFFF_8000_0001);
    do_op("x*2", 32'h1234_5678, 32'd2, 64'h0000_0000_2468_ACF0);

    // Start held high through RUN with new operands: ignored until the
    // completion, then accepted back-to-back on edge 17.
    @(negedge clk);
    Q = 32'd12;
    M = 32'd12;
    start = 1'b1;
    @(negedge clk);
    Q = 32'd9;
    M = 32'd9;
    wait_done("held 12*12", 64'd144, 1'b1);
    wait_done("b2b 9*9", 64'd81, 1'b0);

    // Asynchronous clear in the middle of an operation.
    @(negedge clk);
    Q = 32'd1000;
    M = 32'd1000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 clear = 1'b1;
    #1;
    check("clear ready", 64'(ready), 64'd1);
    check("clear done", 64'(done), 64'd0);
    check("clear result", result, 64'd0);
    @(negedge clk);
    clear = 1'b0;
    repeat (3) @(negedge clk);
    check("post-clear no done", 64'(done), 64'd0);
    check("post-clear result", result, 64'd0);
    do_op("2*3", 32'd2, 32'd3, 64'd6);

    for (int i = 0; i < 100; i++) begin
      logic [W-1:0] q;
      logic [W-1:0] m;
      longint       qs;
      longint       ms;
      q  = $urandom;
      m  = $urandom;
      qs = $signed(q);
      ms = $signed(m);
      do_op($sformatf("rand%0d", i), q, m, 64'(qs * ms));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_booth_mult_seq
